// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display: one shared decoder,
// one-hot active-low anodes, ghost blanking between digits and tear-free double-buffered loads.
module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  lzb_en,
  output logic                  ready,
  output logic [3:0]            dig_bcd,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [4*DIGITS-1:0] active, shadow;
  logic                pending;
  logic                started;
  logic                commit;
  logic                accept;
  logic [DIGITS-1:0]   lz;
  logic                lz_run;
  logic [3:0]          cur_nib;
  logic                cur_blank;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    commit    = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            commit  = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // lz[i] is set when digit i and every more significant digit are zero
  always_comb begin
    lz        = '0;
    lz_run    = 1'b1;
    cur_nib   = 4'hF;
    cur_blank = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (active[4*i +: 4] == 4'h0);
      lz[i]  = lz_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = active[4*i +: 4];
        cur_blank = (i != 0) && lz[i];
      end
    end
  end

  assign ready      = ~pending;
  assign accept     = load && ready;
  assign dig_bcd    = (lzb_en && cur_blank) ? 4'hF : cur_nib;
  assign an_n       = (state == SHOW) ? ~(DIGITS'(1) << idx) : '1;
  assign frame_tick = started && (state == BLANK) && (idx == '0) && (cnt == '0);

  // active only moves on the frame-wrap edge so a frame never mixes old and new digits
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BLANK;
      cnt     <= '0;
      idx     <= '0;
      active  <= '1;
      shadow  <= '1;
      pending <= 1'b0;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      started <= 1'b1;
      if (commit) begin
        if (accept) begin
          active <= bcd_in;
        end else if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (accept) begin
        shadow  <= bcd_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2: digit 6 cycles, frame 24).
// Expectations are keyed by absolute cycle number; the monitor compares on each falling edge.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        lzb_en;
  logic        ready;
  logic [3:0]  dig_bcd;
  logic [3:0]  an_n;
  logic        frame_tick;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int R, R2;

  typedef struct {
    int t;
    int an;
    int dig;
    int rdy;
    int ft;
  } exp_t;

  exp_t sb[$];

  seg_scan_ctrl #(
    .DIGITS(4),
    .REFRESH_DIV(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .bcd_in(bcd_in),
    .lzb_en(lzb_en),
    .ready(ready),
    .dig_bcd(dig_bcd),
    .an_n(an_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A field of -1 means "not checked at this cycle"
  task automatic expect_at(input int t, input int an, input int dig, input int rdy, input int ft);
    exp_t e;
    e.t = t; e.an = an; e.dig = dig; e.rdy = rdy; e.ft = ft;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int t, input int act, input int req);
    if (req >= 0) begin
      total++;
      if (act == req) passed++;
      else $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, t, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].t == cyc) begin
        chk("an_n",       cyc, int'(an_n),       sb[i].an);
        chk("dig_bcd",    cyc, int'(dig_bcd),    sb[i].dig);
        chk("ready",      cyc, int'(ready),      sb[i].rdy);
        chk("frame_tick", cyc, int'(frame_tick), sb[i].ft);
        sb.delete(i);
      end
    end
  end

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int c, input logic [15:0] v);
    go(c);
    load   = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1;
    load   = 1'b0;
    bcd_in = 16'hAAAA;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = 16'h0000;
    lzb_en = 1'b0;
    expect_at(1, 'hF, 'hF, 1, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    R   = cyc;

    // reset state, first lit digit, first frame tick
    expect_at(R + 0,  'hF, 'hF, 1, 0);
    expect_at(R + 1,  'hF, 'hF, -1, 0);
    expect_at(R + 2,  'hE, 'hF, 1, 0);
    expect_at(R + 23, 'h7, 'hF, -1, 0);
    expect_at(R + 24, 'hF, 'hF, 1, 1);

    // mid-frame load waits for the frame wrap
    expect_at(R + 31, -1,  -1,  0, -1);
    expect_at(R + 32, 'hD, 'hF, 0, 0);
    expect_at(R + 47, 'h7, 'hF, 0, 0);
    expect_at(R + 48, 'hF, 'h4, 1, 1);
    expect_at(R + 49, -1,  -1,  1, 0);
    expect_at(R + 50, 'hE, 'h4, -1, -1);
    expect_at(R + 53, 'hE, 'h4, -1, -1);
    expect_at(R + 54, 'hF, 'h3, -1, -1);
    expect_at(R + 56, 'hD, 'h3, -1, -1);
    expect_at(R + 62, 'hB, 'h2, -1, -1);
    expect_at(R + 68, 'h7, 'h1, -1, -1);
    do_load(R + 30, 16'h1234);

    // leading-zero blanking
    expect_at(R + 76,  -1,  -1,  0, -1);
    expect_at(R + 80,  'hD, 'h3, -1, -1);
    expect_at(R + 98,  'hE, 'h0, -1, -1);
    expect_at(R + 104, 'hD, 'h5, -1, -1);
    expect_at(R + 110, 'hB, 'hF, -1, -1);
    expect_at(R + 116, 'h7, 'hF, -1, -1);
    expect_at(R + 122, 'hE, 'h0, -1, -1);
    expect_at(R + 128, 'hD, 'hF, -1, -1);
    expect_at(R + 134, 'hB, 'hF, -1, -1);
    expect_at(R + 140, 'h7, 'hF, -1, -1);
    expect_at(R + 142, 'h7, 'h0, -1, -1);
    expect_at(R + 143, 'h7, 'hF, -1, -1);
    expect_at(R + 146, 'hE, 'h2, -1, -1);
    expect_at(R + 152, 'hD, 'h0, -1, -1);
    expect_at(R + 158, 'hB, 'h1, -1, -1);
    expect_at(R + 164, 'h7, 'hF, -1, -1);
    go(R + 75);
    lzb_en = 1'b1;
    do_load(R + 75, 16'h0050);
    do_load(R + 100, 16'h0000);
    do_load(R + 125, 16'h0102);
    go(R + 142);
    lzb_en = 1'b0;
    go(R + 143);
    lzb_en = 1'b1;

    // second load while busy is dropped
    expect_at(R + 151, -1,  -1,  0, -1);
    expect_at(R + 152, -1,  -1,  0, -1);
    expect_at(R + 170, 'hE, 'h4, -1, -1);
    expect_at(R + 176, 'hD, 'h3, -1, -1);
    expect_at(R + 182, 'hB, 'h2, -1, -1);
    expect_at(R + 188, 'h7, 'h1, -1, -1);
    go(R + 150);
    load   = 1'b1;
    bcd_in = 16'h1234;
    @(posedge clk);
    #1;
    bcd_in = 16'h5678;
    @(posedge clk);
    #1;
    load   = 1'b0;
    bcd_in = 16'hAAAA;

    // load exactly on the frame-wrap edge goes straight to the display
    expect_at(R + 191, -1,  -1,  1, 0);
    expect_at(R + 192, 'hF, 'h6, 1, 1);
    expect_at(R + 194, 'hE, 'h6, -1, -1);
    expect_at(R + 200, 'hD, 'h7, -1, -1);
    expect_at(R + 206, 'hB, 'h8, -1, -1);
    expect_at(R + 212, 'h7, 'h9, -1, -1);
    expect_at(R + 215, -1,  -1,  1, -1);
    do_load(R + 191, 16'h9876);

    // reset in the middle of digit 2's lit period
    R2 = R + 232;
    expect_at(R + 231, 'hB, 'h8, 1, 0);
    expect_at(R2 + 0,  'hF, 'hF, 1, 0);
    expect_at(R2 + 2,  'hE, 'hF, 1, 0);
    expect_at(R2 + 24, 'hF, 'hF, 1, 1);
    expect_at(R2 + 26, 'hE, 'hF, -1, -1);
    expect_at(R2 + 31, -1,  -1,  0, -1);
    expect_at(R2 + 50, 'hE, 'h4, -1, -1);
    expect_at(R2 + 56, 'hD, 'h3, -1, -1);
    go(R + 231);
    rst = 1'b1;
    go(R2);
    rst = 1'b0;
    do_load(R2 + 30, 16'h1234);

    go(R2 + 60);
    @(negedge clk);
    #1;
    foreach (sb[i]) begin
      total++;
      $display("FAIL unchecked_expectation: cycle %0d never compared (now %0d), required cycle <= %0d", sb[i].t, cyc, cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
